// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the 4-bit CPU fetch path: opcode constants, instruction
// field positions and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int INSTR_W = 8;
    localparam int OP_W    = 4;
    localparam int IMM_W   = 4;
    localparam int ADDR_W  = 4;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_JNC = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP = 4'b1111;

    // ST_HOLD is only reachable when single-step support is compiled in.
    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: increment, unconditional jump, or jump-if-no-carry.
// Also flags branch opcodes, which are resolved in fetch and never issued.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    input  logic [OP_W-1:0]   op,
    input  logic [IMM_W-1:0]  imm,
    input  logic              carry,
    output logic [ADDR_W-1:0] next_pc,
    output logic              branch
);

    always_comb begin
        next_pc = pc + 4'd1;
        branch  = 1'b0;
        case (op)
            OP_JMP: begin
                next_pc = imm;
                branch  = 1'b1;
            end
            OP_JNC: begin
                branch = 1'b1;
                if (!carry) begin
                    next_pc = imm;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/decode/issue front end of the 4-bit CPU: PC, IR and the issue handshake.
// Optional single-step mode (adds `step` input and HOLD state) under FETCH_SINGLE_STEP_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 4'h0
) (
    input  logic                clk_cpu,
    input  logic                reset,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [ADDR_W-1:0]   adrs,
    input  logic [INSTR_W-1:0]  rom_dat,
    input  logic                carry_in,
    output logic                iss_valid,
    input  logic                iss_ready,
    output logic [OP_W-1:0]     iss_op,
    output logic [IMM_W-1:0]    iss_imm,
    output logic [ADDR_W-1:0]   pc_out
);

    // Where the FSM goes after reset, a handshake or a resolved jump.
`ifdef FETCH_SINGLE_STEP_EN
    localparam state_t ST_RESUME = ST_HOLD;
`else
    localparam state_t ST_RESUME = ST_FETCH;
`endif

    state_t               state_reg, state_next;
    logic [ADDR_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0]   ir_reg, ir_next;
    logic                 valid_reg, valid_next;
    logic [OP_W-1:0]      op_reg, op_next;
    logic [IMM_W-1:0]     imm_reg, imm_next;
    logic [ADDR_W-1:0]    pc_out_reg, pc_out_next;

    logic [ADDR_W-1:0]    sel_pc;
    logic                 is_branch;

    fetch_unit_pc_next u_pc_next (
        .pc      (pc_reg),
        .op      (ir_reg[OP_MSB:OP_LSB]),
        .imm     (ir_reg[IMM_MSB:IMM_LSB]),
        .carry   (carry_in),
        .next_pc (sel_pc),
        .branch  (is_branch)
    );

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        ir_next     = ir_reg;
        valid_next  = valid_reg;
        op_next     = op_reg;
        imm_next    = imm_reg;
        pc_out_next = pc_out_reg;

        case (state_reg)
            ST_FETCH: begin
                ir_next     = rom_dat;
                pc_out_next = pc_reg;
                state_next  = ST_DECODE;
            end
            ST_DECODE: begin
                pc_next = sel_pc;
                if (is_branch) begin
                    state_next = ST_RESUME;
                end else begin
                    // Undefined opcodes go out unchanged; execute treats them as NOP.
                    valid_next = 1'b1;
                    op_next    = ir_reg[OP_MSB:OP_LSB];
                    imm_next   = ir_reg[IMM_MSB:IMM_LSB];
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iss_ready) begin
                    valid_next = 1'b0;
                    state_next = ST_RESUME;
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_HOLD: begin
                if (step) begin
                    state_next = ST_FETCH;
                end
            end
`endif
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_RESUME;
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            valid_reg  <= 1'b0;
            op_reg     <= '0;
            imm_reg    <= '0;
            pc_out_reg <= RESET_PC;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            ir_reg     <= ir_next;
            valid_reg  <= valid_next;
            op_reg     <= op_next;
            imm_reg    <= imm_next;
            pc_out_reg <= pc_out_next;
        end
    end

    assign adrs      = pc_reg;
    assign iss_valid = valid_reg;
    assign iss_op    = op_reg;
    assign iss_imm   = imm_reg;
    assign pc_out    = pc_out_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected issues are queued per program and
// matched against each valid/ready handshake; covers jumps, stalls, wrap and reset.
module tb_fetch_unit;

    logic       clk_cpu = 1'b0;
    logic       reset   = 1'b0;
    logic [3:0] adrs;
    logic [7:0] rom_dat;
    logic       carry_in  = 1'b0;
    logic       iss_valid;
    logic       iss_ready = 1'b0;
    logic [3:0] iss_op;
    logic [3:0] iss_imm;
    logic [3:0] pc_out;

`ifdef FETCH_SINGLE_STEP_EN
    logic step = 1'b1;
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    always #5 clk_cpu = ~clk_cpu;

    logic [7:0] rom [16];
    assign rom_dat = rom[adrs];

    typedef struct {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] pc;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    fetch_unit #(.RESET_PC(4'h0)) dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
`ifdef FETCH_SINGLE_STEP_EN
        .step      (step),
`endif
        .adrs      (adrs),
        .rom_dat   (rom_dat),
        .carry_in  (carry_in),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_op    (iss_op),
        .iss_imm   (iss_imm),
        .pc_out    (pc_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] op, input logic [3:0] imm, input logic [3:0] pc, input int c);
        exp_t e;
        e.op  = op;
        e.imm = imm;
        e.pc  = pc;
        e.cyc = STEP_MODE ? -1 : c;
        sb.push_back(e);
    endtask

    // Every location defaults to a jump-to-self so programs park instead of running off.
    task automatic rom_clear();
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'hF, 4'(i)};
        end
    endtask

    task automatic apply_reset();
        @(posedge clk_cpu);
        #1 reset = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b1;
    endtask

    task automatic drain(input int budget, input int idle);
        for (int i = 0; i < budget && sb.size() > 0; i++) begin
            @(negedge clk_cpu);
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        repeat (idle) @(negedge clk_cpu);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !iss_valid; i++) begin
            @(negedge clk_cpu);
        end
        check(tag, 32'(iss_valid), 32'd1);
    endtask

    always @(posedge clk_cpu) begin
        cyc <= reset ? cyc + 1 : 0;
    end

    always @(negedge clk_cpu) begin
        if (reset && iss_valid && iss_ready) begin
            $display("issue op=%h imm=%h pc=%h cyc=%0d", iss_op, iss_imm, pc_out, cyc);
            if (sb.size() == 0) begin
                check("spurious_issue", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("iss_op", 32'(iss_op), 32'(mon_e.op));
                check("iss_imm", 32'(iss_imm), 32'(mon_e.imm));
                check("pc_out", 32'(pc_out), 32'(mon_e.pc));
                if (mon_e.cyc >= 0) begin
                    check("issue_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, issue latency, JMP resolution.
        rom_clear();
        rom[0]  = 8'h03;
        rom[1]  = 8'h15;
        rom[2]  = 8'hFA;
        rom[10] = 8'h27;
        iss_ready = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk_cpu);
        check("rst_adrs", 32'(adrs), 32'h0);
        check("rst_valid", 32'(iss_valid), 32'h0);
        check("rst_op", 32'(iss_op), 32'h0);
        check("rst_imm", 32'(iss_imm), 32'h0);
        check("rst_pc_out", 32'(pc_out), 32'h0);
        push(4'h0, 4'h3, 4'h0, 2);
        push(4'h1, 4'h5, 4'h1, 5);
        push(4'h2, 4'h7, 4'hA, 10);
        reset = 1'b1;
`ifndef FETCH_SINGLE_STEP_EN
        while (cyc < 8) @(negedge clk_cpu);
        check("jmp_adrs", 32'(adrs), 32'hA);
`endif
        drain(60, 6);
        check("jmp_park_adrs", 32'(adrs), 32'hB);

        // JNC taken with carry clear.
        rom_clear();
        rom[0] = 8'hE7;
        rom[7] = 8'h47;
        rom[8] = 8'h58;
        rom[1] = 8'h61;
        carry_in = 1'b0;
        apply_reset();
        push(4'h4, 4'h7, 4'h7, 4);
        push(4'h5, 4'h8, 4'h8, 7);
        drain(60, 6);
        check("jnc_taken_park", 32'(adrs), 32'h9);

        // JNC not taken with carry set.
        carry_in = 1'b1;
        apply_reset();
        push(4'h6, 4'h1, 4'h1, 4);
        drain(60, 6);
        check("jnc_fall_park", 32'(adrs), 32'h2);
        carry_in = 1'b0;

        // Back-pressure: undefined opcode held stable while iss_ready is low.
        rom_clear();
        rom[0] = 8'h8C;
        iss_ready = 1'b0;
        apply_reset();
        push(4'h8, 4'hC, 4'h0, 8);
        wait_valid("stall_valid_seen");
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(iss_valid), 32'h1);
            check("stall_op", 32'(iss_op), 32'h8);
            check("stall_imm", 32'(iss_imm), 32'hC);
            check("stall_adrs", 32'(adrs), 32'h1);
            @(negedge clk_cpu);
        end
        @(posedge clk_cpu);
        #1 iss_ready = 1'b1;
        drain(20, 6);

        // PC wrap from F to 0.
        rom_clear();
        rom[0]  = 8'hFE;
        rom[14] = 8'h1A;
        rom[15] = 8'h2B;
        apply_reset();
        push(4'h1, 4'hA, 4'hE, -1);
        push(4'h2, 4'hB, 4'hF, -1);
        push(4'h1, 4'hA, 4'hE, -1);
        for (int i = 0; i < 40 && !(iss_valid && iss_imm == 4'hB); i++) begin
            @(negedge clk_cpu);
        end
        check("wrap_seen", 32'(iss_imm), 32'hB);
        check("wrap_adrs", 32'(adrs), 32'h0);
        drain(60, 0);

        // Asynchronous reset in the middle of ISSUE.
        rom_clear();
        rom[0] = 8'h03;
        rom[1] = 8'h15;
        iss_ready = 1'b0;
        apply_reset();
        wait_valid("midrst_valid_seen");
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", 32'(iss_valid), 32'h0);
        check("midrst_adrs", 32'(adrs), 32'h0);
        sb.delete();
        iss_ready = 1'b1;
        repeat (2) @(posedge clk_cpu);
        @(negedge clk_cpu);
        push(4'h0, 4'h3, 4'h0, 2);
        push(4'h1, 4'h5, 4'h1, 5);
        reset = 1'b1;
        drain(60, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
